// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Counter width for a given operand width, never narrower than 1 bit.
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial unsigned subtractor, diff = a - b over WIDTH cycles.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed overflow flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;

    logic bit_d;
    logic bit_bout;
    logic accept;
    logic last;

    full_subtractor u_fs (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .bin (borrow_q),
        .d   (bit_d),
        .bout(bit_bout)
    );

    assign accept = (state_q == IDLE) & start_valid;
    assign last   = (state_q == SHIFT) & (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_d    = res_q >> 1;
                res_d[WIDTH-1] = bit_d;
                borrow_d = bit_bout;
                if (last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // bit_d on the last shift is the result MSB
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end
        if (last) begin
            ovf_d = (a_msb_q != b_msb_q) & (bit_d != a_msb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = accept;
    assign overflow   = 1'b0;
`endif

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign diff        = res_q;
    assign borrow_out  = borrow_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first unsigned subtractor computing a - b over WIDTH clock cycles.
- Uses one full-subtractor cell and a borrow flip-flop; this is the inverse arithmetic counterpart of the team's full-adder datapath.
- Valid/ready handshakes on the operand input and the result output.
- Intended for area-constrained arithmetic paths where latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  operands a/b present.
- start_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, sampled only on accept.
- b  input  WIDTH  subtrahend, sampled only on accept.
- done_valid  output  1  result valid.
- done_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow_out  output  1  1 when a < b (unsigned).
- overflow  output  1  signed overflow flag (see Optional Feature).
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, borrow=0, operand and result registers=0. Outputs: start_ready=1 once out of reset, done_valid=0, diff=0, borrow_out=0, overflow=0, busy=0.
- Reset mid-operation aborts immediately and discards the partial result. There is no recovery of the in-flight operation.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - Accept = start_valid & start_ready at a rising edge. On accept: load a_sr<=a, b_sr<=b, borrow<=0, cnt<=0, go to SHIFT.
- SHIFT (start_ready=0):
  - Each edge: bit d = a_sr[0]^b_sr[0]^borrow; borrow <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow).
  - d shifts into the result register MSB; the result register shifts right; a_sr and b_sr shift right.
  - cnt increments each edge. On the edge where cnt==WIDTH-1, go to DONE.
- Latency: done_valid rises exactly WIDTH edges after the accepting edge. WIDTH=1 gives 1 SHIFT cycle.
- DONE:
  - done_valid=1; diff, borrow_out and overflow are stable.
  - Hold until done_ready=1 at an edge, then go to IDLE.
  - Back-pressure is unlimited.
- Throughput: one operation per WIDTH+2 cycles minimum. start_ready is never high in the same cycle as done_valid.
- Inputs a/b/start_valid are ignored outside IDLE, and changes during SHIFT have no effect.
- diff, borrow_out and overflow keep the last result after the DONE handshake until the next accept.
- During SHIFT these outputs are unspecified; benches check them only while done_valid=1.
- cnt width is clog2(WIDTH), minimum 1. There is no wrap beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: overflow is registered on entry to DONE as (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]), using the operand MSBs captured at accept.
- Not defined: overflow is tied to 0 and no MSB capture registers are built.
- The port exists in both cases.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a CNT_W function/constant derived from WIDTH.
- One sub-module: full_subtractor (combinational; inputs x, y, bin; outputs d, bout), instantiated once.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan (WIDTH=8):
- Basic: a=0x5A, b=0x23, accept at edge E0 -> done_valid at E8, diff=0x37, borrow_out=0.
- Borrow:
  - a=0x10, b=0x20 -> diff=0xF0, borrow_out=1.
  - a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
  - a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
- Back-pressure: hold done_ready=0 for 5 cycles while driving start_valid=1 with new operands -> done_valid, diff and borrow_out are stable, start_ready=0, no new accept. Release -> IDLE next edge, new operands accepted.
- Reset mid-op: pulse rst_n low at 4th SHIFT cycle -> done_valid=0, busy=0, diff=0 immediately. After release, start_ready=1 and a fresh a=0x03, b=0x01 yields diff=0x02.
- Input stability: change a/b every cycle during SHIFT -> result matches the operands captured at accept.
- With SERIAL_SUBTRACTOR_OVF_EN:
  - a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0.
  - a=0x7F, b=0xFF -> diff=0x80, overflow=1, borrow_out=1.
  - Without the macro, overflow=0 for both.
